ref_col_loader: RTL and testbench
=================================

REF_COL_LOADER -- requirements
Module: ref_col_loader

Interface
REQ-001 SHALL have parameter PIXEL, default 8, meaning bits per pixel.
REQ-002 SHALL have parameter ROWS, default 8, meaning pixels per column word.
REQ-003 SHALL have parameter COLS, default 32, meaning columns per window.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 flush  input  1  synchronous clear of the window fill, active-high.
REQ-007 col_valid  input  1  column word present on col_in.
REQ-008 col_in  input  ROWS*PIXEL  one reference column; row r at bits [(r+1)*PIXEL-1 : r*PIXEL].
REQ-009 col_ready  output  1  loader accepts col_in this cycle.
REQ-010 win_valid  output  1  ref_ou holds a complete window.
REQ-011 win_ready  input  1  consumer takes the window this cycle.
REQ-012 ref_ou  output  ROWS*COLS*PIXEL  window; column c, row r at bits [(c*ROWS+r+1)*PIXEL-1 : (c*ROWS+r)*PIXEL].
REQ-013 fill_cnt  output  6  accepted columns in the current window, 0..COLS.

Function
REQ-014 Column accepted SHALL mean col_valid && col_ready on a rising edge; window taken SHALL mean win_valid && win_ready.
REQ-015 Each accepted column SHALL shift the window one column toward column 0: column c takes column c+1, column COLS-1 takes col_in, column 0 is discarded.
REQ-016 After COLS accepted columns, the first accepted column SHALL sit in column 0 and the last in column COLS-1.
REQ-017 State machine SHALL have states FILL and FULL; reset and flush enter FILL.
REQ-018 In FILL: col_ready=1, win_valid=0; fill_cnt increments per accepted column.
REQ-019 The accept that brings fill_cnt to COLS SHALL move to FULL, and win_valid SHALL be 1 on the next cycle (latency 1 cycle from the last column edge).
REQ-020 In FULL without the slide feature: col_ready=0, ref_ou and fill_cnt held stable until the window is taken; on the take, the state SHALL return to FILL with fill_cnt=0 and ref_ou content unchanged.
REQ-021 win_valid SHALL stay asserted while win_ready=0; ref_ou SHALL not change while win_valid=1 and win_ready=0.
REQ-022 flush SHALL override all other inputs: next cycle FILL, fill_cnt=0, win_valid=0, any column presented that cycle dropped; ref_ou content is not cleared.
REQ-023 fill_cnt SHALL saturate at COLS and never wrap.

Reset
REQ-024 While rst_n=0 at a clock edge: state FILL, fill_cnt=0, win_valid=0, ref_ou all zeros; col_ready SHALL read 1 in the first cycle after reset release.
REQ-025 Reset mid-fill or mid-FULL SHALL discard the partial or pending window without any win_valid pulse.

Configuration
REQ-026 Macro REF_SLIDE_EN SHALL select sliding-window mode.
REQ-027 With REF_SLIDE_EN defined, in FULL: col_ready=win_ready; a take with a simultaneous column accept SHALL shift one column in and keep win_valid=1 next cycle (new window every column); a take without a column SHALL return to FILL with fill_cnt=COLS-1.
REQ-028 Without REF_SLIDE_EN, behaviour SHALL be block mode per REQ-020; no sliding logic synthesised.

Structure
REQ-029 PIXEL, ROWS, COLS defaults and the FILL/FULL state enum SHALL live in a shared package me_ref_pkg, used also by the row separator downstream.
REQ-030 No sub-module; the shift register and control SHALL be one module.

Verification
REQ-031 Reset, then 32 columns back-to-back with col_in row r = 8'(c*8+r) -> win_valid=1 one cycle after 32nd accept; ref_ou pixel (c,r) = c*8+r; fill_cnt=32.
REQ-032 Full window, win_ready=0 for 5 cycles, col_valid=1 -> col_ready=0, ref_ou stable; win_ready=1 -> win_valid=0 next cycle, fill_cnt=0.
REQ-033 flush asserted after 17 columns together with col_valid -> fill_cnt=0, win_valid=0; 32 fresh columns give a window with none of the old 17 values.
REQ-034 rst_n=0 while win_valid=1 -> next cycle win_valid=0, fill_cnt=0, ref_ou=0, col_ready=1.
REQ-035 REF_SLIDE_EN: 40 columns c=0..39 with win_ready=1 -> windows on 9 consecutive cycles; last window column 0 = column 8 data, column 31 = column 39 data.
REQ-036 Random col_valid/win_ready gaps (50%) over 10 windows -> every window matches a software model of the shift sequence, with no column lost or duplicated.

Source files
------------

// File: rtl/me_ref_pkg.sv
// Shared reference-window definitions for the column loader and the downstream row separator.
package me_ref_pkg;

  localparam int unsigned PIXEL_DEF = 8;
  localparam int unsigned ROWS_DEF  = 8;
  localparam int unsigned COLS_DEF  = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } ref_state_e;

endpackage

// File: rtl/ref_col_loader.sv
// Reference column loader: shifts column words into a COLS-wide window and
// hands the complete window to a consumer with a valid/ready handshake.
// Define REF_SLIDE_EN for sliding-window mode (a new window on every column
// once full); the default build is block mode (refill after each take).
module ref_col_loader
  import me_ref_pkg::*;
#(
  parameter int unsigned PIXEL = PIXEL_DEF,
  parameter int unsigned ROWS  = ROWS_DEF,
  parameter int unsigned COLS  = COLS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        col_valid,
  input  logic [ROWS*PIXEL-1:0]       col_in,
  output logic                        col_ready,
  output logic                        win_valid,
  input  logic                        win_ready,
  output logic [ROWS*COLS*PIXEL-1:0]  ref_ou,
  output logic [5:0]                  fill_cnt
);

  localparam int unsigned COL_W = ROWS * PIXEL;
  localparam int unsigned WIN_W = COL_W * COLS;

  ref_state_e        state_q, state_d;
  logic [CNT_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  win_shift;
  logic [CNT_W-1:0]  cnt_inc;
  logic              col_acc;
  logic              win_take;

  // Handshake decode straight from the state register.
  assign win_valid = (state_q == FULL);
`ifdef REF_SLIDE_EN
  assign col_ready = (state_q == FILL) || win_ready;
`else
  assign col_ready = (state_q == FILL);
`endif

  assign col_acc  = col_valid && col_ready;
  assign win_take = win_valid && win_ready;

  // Window moves one column toward column 0; the new column enters at the top.
  assign win_shift = {col_in, win_q[WIN_W-1:COL_W]};

  // Saturating fill count increment.
  assign cnt_inc = (fill_cnt_q == CNT_W'(COLS)) ? fill_cnt_q : fill_cnt_q + CNT_W'(1);

  assign ref_ou   = win_q;
  assign fill_cnt = fill_cnt_q;

  // Next-state, fill count and window contents.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    win_d      = win_q;
    if (flush) begin
      // Window contents are kept; only the fill is abandoned.
      state_d    = FILL;
      fill_cnt_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (col_acc) begin
            win_d      = win_shift;
            fill_cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(COLS)) begin
              state_d = FULL;
            end
          end
        end
        FULL: begin
          if (win_take) begin
`ifdef REF_SLIDE_EN
            if (col_acc) begin
              win_d = win_shift;
            end else begin
              state_d    = FILL;
              fill_cnt_d = CNT_W'(COLS - 1);
            end
`else
            state_d    = FILL;
            fill_cnt_d = '0;
`endif
          end
        end
        default: begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end
      endcase
    end
  end

  // State, count and window registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      win_q      <= win_d;
    end
  end

endmodule

// File: tb/tb_ref_col_loader.sv
// Directed and randomised checks of ref_col_loader (default parameters).
module tb_ref_col_loader;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          col_valid;
  logic [63:0]   col_in;
  logic          col_ready;
  logic          win_valid;
  logic          win_ready;
  logic [2047:0] ref_ou;
  logic [5:0]    fill_cnt;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef REF_SLIDE_EN
  localparam bit SLIDE    = 1'b1;
  localparam int TAKE_CNT = 31;
`else
  localparam bit SLIDE    = 1'b0;
  localparam int TAKE_CNT = 0;
`endif

  ref_col_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .col_valid (col_valid),
    .col_in    (col_in),
    .col_ready (col_ready),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .ref_ou    (ref_ou),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Column word with row r = base + c*8 + r (mod 256).
  function automatic logic [63:0] mk(input int c, input int base);
    logic [63:0] v;
    for (int r = 0; r < 8; r++) v[r*8 +: 8] = 8'(base + c*8 + r);
    return v;
  endfunction

  function automatic logic [63:0] col(input int i);
    return ref_ou[i*64 +: 64];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      col_valid = 1'b1;
      col_in    = mk(i, base);
      step();
    end
    col_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  logic [63:0] mwin[32];
  bit          mfull;
  int          mcnt;
  int          wins;
  int          cyc;
  int          nwin;
  bit          exp_rdy;
  bit          acc;

  initial begin
    rst_n = 1'b0; flush = 1'b0; col_valid = 1'b0; col_in = '0; win_ready = 1'b0;
    step(); step();
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_fill_cnt", 64'(fill_cnt), 64'd0);
    chk("rst_col0", col(0), 64'd0);
    chk("rst_col31", col(31), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_col_ready", 64'(col_ready), 64'd1);

    // 32 columns back to back; window one cycle after the last accept.
    fill(0, 31);
    chk("fill31_cnt", 64'(fill_cnt), 64'd31);
    chk("fill31_valid", 64'(win_valid), 64'd0);
    col_valid = 1'b1; col_in = mk(31, 0);
    step();
    col_valid = 1'b0;
    chk("full_valid", 64'(win_valid), 64'd1);
    chk("full_cnt", 64'(fill_cnt), 64'd32);
    for (int c = 0; c < 32; c++) chk($sformatf("full_col%0d", c), col(c), mk(c, 0));

    // Hold under back-pressure with a column offered.
    win_ready = 1'b0; col_valid = 1'b1; col_in = 64'hdead_beef_cafe_f00d;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_col_ready", 64'(col_ready), 64'd0);
      chk("hold_valid", 64'(win_valid), 64'd1);
      chk("hold_cnt", 64'(fill_cnt), 64'd32);
      chk("hold_col0", col(0), mk(0, 0));
      chk("hold_col31", col(31), mk(31, 0));
    end
    col_valid = 1'b0; win_ready = 1'b1;
    step();
    win_ready = 1'b0;
    chk("take_valid", 64'(win_valid), 64'd0);
    chk("take_cnt", 64'(fill_cnt), 64'(TAKE_CNT));
    chk("take_col5", col(5), mk(5, 0));

    // Flush after 17 columns, with a column offered on the flush cycle.
    do_flush();
    fill(8'h80, 17);
    chk("pre_flush_cnt", 64'(fill_cnt), 64'd17);
    flush = 1'b1; col_valid = 1'b1; col_in = 64'h0123_4567_89ab_cdef;
    step();
    flush = 1'b0; col_valid = 1'b0;
    chk("flush_cnt", 64'(fill_cnt), 64'd0);
    chk("flush_valid", 64'(win_valid), 64'd0);
    chk("flush_col_ready", 64'(col_ready), 64'd1);
    fill(8'h40, 32);
    chk("refill_valid", 64'(win_valid), 64'd1);
    for (int c = 0; c < 32; c++) chk($sformatf("refill_col%0d", c), col(c), mk(c, 8'h40));
    win_ready = 1'b1;
    step();
    win_ready = 1'b0;

    // Reset while a window is pending.
    do_flush();
    fill(8'h11, 32);
    chk("pend_valid", 64'(win_valid), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", 64'(win_valid), 64'd0);
    chk("midrst_cnt", 64'(fill_cnt), 64'd0);
    chk("midrst_col0", col(0), 64'd0);
    chk("midrst_col31", col(31), 64'd0);
    chk("midrst_col_ready", 64'(col_ready), 64'd1);

    // Reset mid-fill discards the partial window.
    fill(8'h22, 10);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rstfill_cnt", 64'(fill_cnt), 64'd0);
    chk("rstfill_valid", 64'(win_valid), 64'd0);

`ifdef REF_SLIDE_EN
    // Sliding mode: 40 columns with the consumer always ready.
    nwin = 0;
    for (int c = 0; c < 40; c++) begin
      col_valid = 1'b1; win_ready = 1'b1; col_in = mk(c, 0);
      step();
      if (win_valid) nwin++;
    end
    col_valid = 1'b0;
    chk("slide_nwin", 64'(nwin), 64'd9);
    chk("slide_col0", col(0), mk(8, 0));
    chk("slide_col31", col(31), mk(39, 0));
    step();
    win_ready = 1'b0;
    chk("slide_drop_cnt", 64'(fill_cnt), 64'd31);
    chk("slide_drop_valid", 64'(win_valid), 64'd0);
`endif

    // Random gaps on both sides against a column-shift model.
    do_flush();
    mfull = 1'b0; mcnt = 0; wins = 0; cyc = 0;
    for (int i = 0; i < 32; i++) mwin[i] = '0;
    while (wins < 10 && cyc < 5000) begin
      col_valid = 1'($urandom_range(0, 1));
      win_ready = 1'($urandom_range(0, 1));
      col_in    = {$urandom, $urandom};
      #1;
      exp_rdy = !mfull || (SLIDE && win_ready);
      chk("rand_col_ready", 64'(col_ready), 64'(exp_rdy));
      if (mfull && win_ready) begin
        for (int c = 0; c < 32; c++) chk($sformatf("rand_w%0d_col%0d", wins, c), col(c), mwin[c]);
        wins++;
      end
      acc = col_valid && exp_rdy;
      if (mfull) begin
        if (win_ready) begin
          if (SLIDE && acc) begin
            for (int c = 0; c < 31; c++) mwin[c] = mwin[c+1];
            mwin[31] = col_in;
          end else begin
            mfull = 1'b0;
            mcnt  = TAKE_CNT;
          end
        end
      end else if (acc) begin
        for (int c = 0; c < 31; c++) mwin[c] = mwin[c+1];
        mwin[31] = col_in;
        mcnt++;
        if (mcnt == 32) mfull = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("rand_valid", 64'(win_valid), 64'(mfull));
      chk("rand_cnt", 64'(fill_cnt), 64'(mcnt));
      cyc++;
    end
    col_valid = 1'b0; win_ready = 1'b0;
    chk("rand_windows", 64'(wins), 64'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
